ppl_ctrl: RTL and testbench

Pipeline sequencer for the 16-bit interrupt-capable pipelined core. It drives the shared `hold_flag`/`clear_flag` buses that every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) decodes. It resolves load-use hazards, memory-wait stalls, taken-jump flushes and interrupt entry/return, and steers the PC on redirects. It sits beside the decode and execute stages and is the only driver of the stall/flush buses.

---
 rtl/ppl_ctrl_if.sv | 40 ++++
 rtl/ppl_ctrl.sv | 91 +++++++++
 tb/tb_ppl_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ppl_ctrl_if.sv
// ppl_ctrl_if: decode/execute hazard inputs and stall/flush/redirect outputs of the pipeline sequencer
interface ppl_ctrl_if #(
    parameter int DW = 16
);
    logic [2:0]    ID_rs1;
    logic [2:0]    ID_rs2;
    logic          ID_rs1_en;
    logic          ID_rs2_en;
    logic          ID_valid;
    logic [DW-1:0] ID_inst_addr;
    logic [2:0]    EX_rd;
    logic          EX_RegWe;
    logic          EX_RWSel;
    logic          EX_jump_taken;
    logic [DW-1:0] EX_jump_addr;
    logic          EX_mret;
    logic          mem_busy;
    logic          int_req;
    logic [2:0]    hold_flag;
    logic [2:0]    clear_flag;
    logic          pc_redirect;
    logic [DW-1:0] pc_target;
    logic          int_ack;
    logic [DW-1:0] epc;
    logic          int_ie;

    modport master (
        output ID_rs1, ID_rs2, ID_rs1_en, ID_rs2_en, ID_valid, ID_inst_addr,
               EX_rd, EX_RegWe, EX_RWSel, EX_jump_taken, EX_jump_addr, EX_mret,
               mem_busy, int_req,
        input  hold_flag, clear_flag, pc_redirect, pc_target, int_ack, epc, int_ie
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rs1_en, ID_rs2_en, ID_valid, ID_inst_addr,
               EX_rd, EX_RegWe, EX_RWSel, EX_jump_taken, EX_jump_addr, EX_mret,
               mem_busy, int_req,
        output hold_flag, clear_flag, pc_redirect, pc_target, int_ack, epc, int_ie
    );
endinterface

// File: rtl/ppl_ctrl.sv
// ppl_ctrl: pipeline stall/flush/redirect sequencer; interrupt entry/return present only with PPL_CTRL_INT_EN
module ppl_ctrl #(
    parameter int                   DW         = 16,
    parameter int                   CPU_WIDTH  = 16,
    parameter logic [CPU_WIDTH-1:0] INT_VECTOR = 16'h0010
) (
    input logic       clk,
    input logic       rst_n,
    ppl_ctrl_if.slave bus
);
    localparam logic [2:0] HOLD_NONE  = 3'd0;
    localparam logic [2:0] HOLD_ID    = 3'd2;
    localparam logic [2:0] HOLD_PPL   = 3'd4;
    localparam logic [2:0] CLEAR_NONE = 3'd0;
    localparam logic [2:0] CLEAR_EX   = 3'd2;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        r_state;
    logic          w_run;
    logic          w_flush;
    logic          w_load_use;
    logic          w_jump;
    logic          w_mret;
    logic          w_int;
    logic          w_redirect;
    logic          w_lu;
    logic [DW-1:0] w_epc;
    logic          w_int_ie;

    assign w_run   = rst_n & ~bus.mem_busy & (r_state == RUN);
    assign w_flush = rst_n & ~bus.mem_busy & (r_state == FLUSH);
    assign w_load_use = bus.EX_RegWe & bus.EX_RWSel &
                        ((bus.ID_rs1_en & (bus.ID_rs1 == bus.EX_rd)) |
                         (bus.ID_rs2_en & (bus.ID_rs2 == bus.EX_rd)));
    assign w_jump     = w_run & bus.EX_jump_taken;
    assign w_redirect = w_jump | w_mret | w_int;
    assign w_lu       = w_run & ~w_redirect & w_load_use;

`ifdef PPL_CTRL_INT_EN
    logic [DW-1:0] r_epc;
    logic          r_int_ie;

    assign w_mret   = w_run & ~bus.EX_jump_taken & bus.EX_mret;
    assign w_int    = w_run & ~bus.EX_jump_taken & ~bus.EX_mret &
                      bus.int_req & r_int_ie & bus.ID_valid;
    assign w_epc    = r_epc;
    assign w_int_ie = r_int_ie;

    // The squashed ID instruction is the one to resume at after mret
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc    <= '0;
            r_int_ie <= 1'b1;
        end else if (w_int) begin
            r_epc    <= bus.ID_inst_addr;
            r_int_ie <= 1'b0;
        end else if (w_mret) begin
            r_int_ie <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_mret   = 1'b0;
    assign w_int    = 1'b0;
    assign w_epc    = '0;
    assign w_int_ie = 1'b0;
    assign w_unused = ^{bus.EX_mret, bus.int_req, bus.ID_valid, bus.ID_inst_addr};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= RUN;
        else if (!bus.mem_busy)
            r_state <= w_redirect ? FLUSH : RUN;
    end

    // mem_busy freezes everything, so only the hold code survives it
    assign bus.hold_flag   = !rst_n        ? HOLD_NONE :
                             bus.mem_busy  ? HOLD_PPL  :
                             w_lu          ? HOLD_ID   : HOLD_NONE;
    assign bus.clear_flag  = (w_redirect | w_lu | w_flush) ? CLEAR_EX : CLEAR_NONE;
    assign bus.pc_redirect = w_redirect;
    assign bus.pc_target   = w_jump ? bus.EX_jump_addr :
                             w_mret ? w_epc            :
                             w_int  ? DW'(INT_VECTOR)  : '0;
    assign bus.int_ack     = w_int;
    assign bus.epc         = w_epc;
    assign bus.int_ie      = w_int_ie;
endmodule

// File: tb/tb_ppl_ctrl.sv
// tb_ppl_ctrl: scoreboard bench for ppl_ctrl; interrupt vectors follow PPL_CTRL_INT_EN
module tb_ppl_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

`ifdef PPL_CTRL_INT_EN
    localparam logic IER = 1'b1;
`else
    localparam logic IER = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [2:0]  h;
        logic [2:0]  c;
        logic        r;
        logic [15:0] t;
        logic        a;
        logic [15:0] e;
        logic        ie;
    } exp_t;

    exp_t q[$];
    exp_t m;

    ppl_ctrl_if #(.DW(16)) bus ();

    ppl_ctrl #(.DW(16), .CPU_WIDTH(16), .INT_VECTOR(16'h0010)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            m = q.pop_front();
            chk(m.name, "hold",  16'(bus.hold_flag),   16'(m.h));
            chk(m.name, "clear", 16'(bus.clear_flag),  16'(m.c));
            chk(m.name, "redir", 16'(bus.pc_redirect), 16'(m.r));
            chk(m.name, "tgt",   bus.pc_target,        m.t);
            chk(m.name, "ack",   16'(bus.int_ack),     16'(m.a));
            chk(m.name, "epc",   bus.epc,              m.e);
            chk(m.name, "ie",    16'(bus.int_ie),      16'(m.ie));
        end
    end

    task automatic clr();
        bus.ID_rs1 = 3'd0; bus.ID_rs2 = 3'd0; bus.ID_rs1_en = 1'b0; bus.ID_rs2_en = 1'b0;
        bus.ID_valid = 1'b0; bus.ID_inst_addr = 16'h0; bus.EX_rd = 3'd0; bus.EX_RegWe = 1'b0;
        bus.EX_RWSel = 1'b0; bus.EX_jump_taken = 1'b0; bus.EX_jump_addr = 16'h0;
        bus.EX_mret = 1'b0; bus.mem_busy = 1'b0; bus.int_req = 1'b0;
    endtask

    task automatic cyc(input string n, input logic [2:0] h, input logic [2:0] c, input logic r,
                       input logic [15:0] t, input logic a, input logic [15:0] e, input logic ie);
        exp_t x;
        x.name = n; x.h = h; x.c = c; x.r = r; x.t = t; x.a = a; x.e = e; x.ie = ie;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [15:0] addr);
        bus.EX_jump_taken = 1'b1;
        bus.EX_jump_addr  = addr;
    endtask

    task automatic irq(input logic [15:0] addr);
        bus.int_req      = 1'b1;
        bus.ID_valid     = 1'b1;
        bus.ID_inst_addr = addr;
    endtask

    task automatic load_use(input logic [2:0] rd, input logic [2:0] rs2);
        bus.EX_RegWe = 1'b1; bus.EX_RWSel = 1'b1; bus.EX_rd = rd;
        bus.ID_rs2 = rs2; bus.ID_rs2_en = 1'b1; bus.ID_valid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 16'h0, 0, 16'h0, IER);
        rst_n = 1'b1;
        cyc("idle", 0, 0, 0, 16'h0, 0, 16'h0, IER);

        load_use(3'd3, 3'd3);
        cyc("lu_rs2", 2, 2, 0, 16'h0, 0, 16'h0, IER);
        bus.EX_RegWe = 1'b0;
        cyc("lu_bubble", 0, 0, 0, 16'h0, 0, 16'h0, IER);
        clr(); bus.EX_RegWe = 1'b1; bus.EX_RWSel = 1'b1; bus.ID_rs1_en = 1'b1;
        cyc("lu_rs1_r0", 2, 2, 0, 16'h0, 0, 16'h0, IER);
        bus.ID_rs1_en = 1'b0;
        cyc("lu_no_en", 0, 0, 0, 16'h0, 0, 16'h0, IER);
        bus.ID_rs1_en = 1'b1; bus.EX_RWSel = 1'b0;
        cyc("lu_not_load", 0, 0, 0, 16'h0, 0, 16'h0, IER);

        clr(); jump(16'h0040);
        cyc("jmp_c0", 0, 2, 1, 16'h0040, 0, 16'h0, IER);
        load_use(3'd3, 3'd3);
        cyc("jmp_flush", 0, 2, 0, 16'h0, 0, 16'h0, IER);
        clr();
        cyc("jmp_c2", 0, 0, 0, 16'h0, 0, 16'h0, IER);

        jump(16'h0040);
        cyc("mw_jmp", 0, 2, 1, 16'h0040, 0, 16'h0, IER);
        clr(); bus.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc("mw_hold", 4, 0, 0, 16'h0, 0, 16'h0, IER);
        bus.mem_busy = 1'b0;
        cyc("mw_flush", 0, 2, 0, 16'h0, 0, 16'h0, IER);
        cyc("mw_idle", 0, 0, 0, 16'h0, 0, 16'h0, IER);

        jump(16'h0080); bus.mem_busy = 1'b1;
        cyc("mw_run_hold", 4, 0, 0, 16'h0, 0, 16'h0, IER);
        bus.mem_busy = 1'b0;
        cyc("mw_run_jmp", 0, 2, 1, 16'h0080, 0, 16'h0, IER);
        clr();
        cyc("mw_run_flush", 0, 2, 0, 16'h0, 0, 16'h0, IER);
        cyc("mw_run_idle", 0, 0, 0, 16'h0, 0, 16'h0, IER);

`ifdef PPL_CTRL_INT_EN
        irq(16'h0022); bus.mem_busy = 1'b1;
        cyc("int_busy", 4, 0, 0, 16'h0, 0, 16'h0, 1);
        bus.mem_busy = 1'b0;
        cyc("int_take", 0, 2, 1, 16'h0010, 1, 16'h0, 1);
        clr();
        cyc("int_flush", 0, 2, 0, 16'h0, 0, 16'h0022, 0);
        irq(16'h0024);
        cyc("int_ignored", 0, 0, 0, 16'h0, 0, 16'h0022, 0);
        clr(); bus.EX_mret = 1'b1;
        cyc("mret", 0, 2, 1, 16'h0022, 0, 16'h0022, 0);
        clr();
        cyc("mret_flush", 0, 2, 0, 16'h0, 0, 16'h0022, 1);
        cyc("mret_idle", 0, 0, 0, 16'h0, 0, 16'h0022, 1);

        jump(16'h0040); irq(16'h0030);
        cyc("jmp_int", 0, 2, 1, 16'h0040, 0, 16'h0022, 1);
        bus.EX_jump_taken = 1'b0; bus.ID_inst_addr = 16'h0032;
        cyc("jmp_int_flush", 0, 2, 0, 16'h0, 0, 16'h0022, 1);
        bus.ID_valid = 1'b0;
        cyc("int_no_valid", 0, 0, 0, 16'h0, 0, 16'h0022, 1);
        irq(16'h0044);
        cyc("int_late", 0, 2, 1, 16'h0010, 1, 16'h0022, 1);
        clr();
        cyc("int_late_flush", 0, 2, 0, 16'h0, 0, 16'h0044, 0);
        bus.EX_mret = 1'b1;
        cyc("mret2", 0, 2, 1, 16'h0044, 0, 16'h0044, 0);
        clr();
        cyc("mret2_flush", 0, 2, 0, 16'h0, 0, 16'h0044, 1);

        irq(16'h005A);
        cyc("rst_pre", 0, 2, 1, 16'h0010, 1, 16'h0044, 1);
`else
        irq(16'h0022);
        cyc("int_off", 0, 0, 0, 16'h0, 0, 16'h0, 0);
        clr(); bus.EX_mret = 1'b1;
        cyc("mret_off", 0, 0, 0, 16'h0, 0, 16'h0, 0);
        clr(); jump(16'h0040);
        cyc("rst_pre", 0, 2, 1, 16'h0040, 0, 16'h0, 0);
`endif
        clr(); rst_n = 1'b0;
        cyc("rst_in_flush", 0, 0, 0, 16'h0, 0, 16'h0, IER);
        rst_n = 1'b1;
        cyc("rst_release", 0, 0, 0, 16'h0, 0, 16'h0, IER);

        @(negedge clk);
        chk("end", "drain", 16'(q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
